// File: rtl/hour24_tz_counter.sv
// UTC hour counter (0..23) with a runtime-loadable signed time-zone offset and a registered local hour.
// Optional macro HOUR12_EN adds registered 12-hour outputs hours12/pm.
module hour24_tz_counter #(
  parameter int TZ_MIN     = -12,
  parameter int TZ_MAX     = 14,
  parameter int TZ_DEFAULT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       carry_in,
  input  logic       tz_valid,
  input  logic [4:0] tz_offset,
  output logic       tz_ready,
  output logic       tz_err,
  output logic [4:0] utc_hours,
  output logic [4:0] hours,
`ifdef HOUR12_EN
  output logic [3:0] hours12,
  output logic       pm,
`endif
  output logic       day_wrap
);

  typedef enum logic {IDLE, APPLY} state_t;

  localparam logic signed [4:0] TZ_RST    = 5'(TZ_DEFAULT);
  localparam int                HOURS_RI  = ((TZ_DEFAULT % 24) + 24) % 24;
  localparam logic [4:0]        HOURS_RST = 5'(HOURS_RI);

  state_t            state_reg, state_next;
  logic signed [4:0] tz_reg, tz_next;
  logic              offset_ok;
  logic              reject;
  logic signed [6:0] sum;
  logic signed [6:0] sum_adj;
  logic [4:0]        hours_calc;

  assign offset_ok = (int'($signed(tz_offset)) >= TZ_MIN) &&
                     (int'($signed(tz_offset)) <= TZ_MAX);

  // Handshake FSM: one-cycle APPLY window blocks new offsets while hours settles
  always_comb begin
    state_next = state_reg;
    tz_next    = tz_reg;
    reject     = 1'b0;
    tz_ready   = 1'b0;
    case (state_reg)
      IDLE: begin
        tz_ready = 1'b1;
        if (tz_valid) begin
          if (offset_ok) begin
            tz_next    = $signed(tz_offset);
            state_next = APPLY;
          end else begin
            reject = 1'b1;
          end
        end
      end
      APPLY: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // 7 bits: 23 + 14 = 37 does not fit in 6-bit signed
  always_comb begin
    sum     = $signed({2'b00, utc_hours}) + $signed({{2{tz_reg[4]}}, tz_reg});
    sum_adj = sum;
    if (sum < 0)
      sum_adj = sum + 7'sd24;
    else if (sum > 7'sd23)
      sum_adj = sum - 7'sd24;
    hours_calc = sum_adj[4:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      tz_reg    <= TZ_RST;
      utc_hours <= 5'd0;
      hours     <= HOURS_RST;
      tz_err    <= 1'b0;
      day_wrap  <= 1'b0;
    end else begin
      state_reg <= state_next;
      tz_reg    <= tz_next;
      tz_err    <= reject;
      hours     <= hours_calc;
      day_wrap  <= carry_in && (utc_hours == 5'd23);
      if (carry_in)
        utc_hours <= (utc_hours == 5'd23) ? 5'd0 : utc_hours + 5'd1;
    end
  end

`ifdef HOUR12_EN
  localparam logic [3:0] H12_RST = (HOURS_RI == 0) ? 4'd12 :
                                   (HOURS_RI > 12)  ? 4'(HOURS_RI - 12) : 4'(HOURS_RI);
  localparam logic       PM_RST  = (HOURS_RI >= 12);

  logic [4:0] h12_wide;
  logic [3:0] h12_calc;

  always_comb begin
    h12_wide = hours_calc;
    if (hours_calc == 5'd0)
      h12_wide = 5'd12;
    else if (hours_calc > 5'd12)
      h12_wide = hours_calc - 5'd12;
    h12_calc = h12_wide[3:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hours12 <= H12_RST;
      pm      <= PM_RST;
    end else begin
      hours12 <= h12_calc;
      pm      <= (hours_calc >= 5'd12);
    end
  end
`endif

endmodule
